hgw_sram_arb: RTL and testbench

- Arbiter that shares one single-port byte-writable SRAM among N requesters.
- Each requester issues a read or a byte-masked write. Grant is returned in the same cycle as the request.
- Sits between client engines and the SRAM instance. It drives the SRAM ce/we/byte_en/addr/wdata and routes the read response back with a per-requester valid strobe.
- Arbitration is round-robin, with an optional bounded lock so a requester can hold the SRAM for back-to-back accesses.

---
 rtl/hgw_sram_arb.sv | 119 +++++++++++
 tb/tb_hgw_sram_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hgw_sram_arb.sv
// ============================================================================
//  hgw_sram_arb : round-robin arbiter sharing one byte-writable SRAM among N
//                 requesters, with a bounded grant lock.  Rev 1.0
// ============================================================================
`default_nettype none

module hgw_sram_arb #(
   parameter  int N        = 2,
   parameter  int D        = 128,
   parameter  int W        = 4,
   parameter  int MAX_HOLD = 4,
   localparam int AW       = $clog2(D)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       req,
   input  logic [N-1:0]       req_we,
   input  logic [N-1:0]       req_lock,
   input  logic [N*W-1:0]     req_byte_en,
   input  logic [N*AW-1:0]    req_addr,
   input  logic [N*W*8-1:0]   req_wdata,
   output logic [N-1:0]       gnt,
   output logic [N-1:0]       rsp_valid,
   output logic [W*8-1:0]     rsp_rdata,
   output logic               sram_ce,
   output logic               sram_we,
   output logic [W-1:0]       sram_byte_en,
   output logic [AW-1:0]      sram_addr,
   output logic [W*8-1:0]     sram_wdata,
   input  logic [W*8-1:0]     sram_rdata
);

   localparam int       PW       = $clog2(N);
   localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

   logic [PW-1:0] rr_ptr;
   logic          hold_valid;
   logic [PW-1:0] hold_owner;
   logic [3:0]    hold_cnt;

   logic          any_gnt;
   logic [PW-1:0] gidx;
   logic [3:0]    cnt_base;

   // Arbitration: a live lock wins outright, otherwise search upward from rr_ptr.
   // Grant is gated by rst_n so an asserted reset silences the SRAM at once.
   always_comb begin
      logic found;
      int   j;
      found = 1'b0;
      gidx  = '0;
      j     = 0;
      if (hold_valid && req[hold_owner]) begin
         found = 1'b1;
         gidx  = hold_owner;
      end else begin
         for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
               found = 1'b1;
               gidx  = PW'(j);
            end
         end
      end
      any_gnt = found & rst_n;
      gnt     = any_gnt ? (N'(1) << gidx) : '0;
   end

   always_comb begin
      sram_ce      = any_gnt;
      sram_we      = 1'b0;
      sram_byte_en = '0;
      sram_addr    = '0;
      sram_wdata   = '0;
      if (any_gnt) begin
         sram_we      = req_we[gidx];
         sram_byte_en = req_byte_en[gidx*W +: W];
         sram_addr    = req_addr[gidx*AW +: AW];
         sram_wdata   = req_wdata[gidx*W*8 +: W*8];
      end
   end

   assign rsp_rdata = sram_rdata;

   // A grant to anyone other than the current holder starts a fresh hold count.
   assign cnt_base = (hold_valid && (hold_owner == gidx)) ? hold_cnt : 4'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         hold_valid <= 1'b0;
         hold_owner <= '0;
         hold_cnt   <= '0;
         rsp_valid  <= '0;
      end else begin
         rsp_valid <= (any_gnt && !req_we[gidx]) ? gnt : '0;
         if (any_gnt) begin
            rr_ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
            if (req_lock[gidx] && (cnt_base < HOLD_LIM)) begin
               hold_valid <= 1'b1;
               hold_owner <= gidx;
               hold_cnt   <= cnt_base + 4'd1;
            end else begin
               hold_valid <= 1'b0;
               hold_owner <= '0;
               hold_cnt   <= '0;
            end
         end else begin
            hold_valid <= 1'b0;
            hold_owner <= '0;
            hold_cnt   <= '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hgw_sram_arb.sv
// ============================================================================
//  tb_hgw_sram_arb : directed bench with SRAM model and read-response scoreboard.
//                    Rev 1.0
// ============================================================================
`default_nettype none

module tb_hgw_sram_arb;
   localparam int N  = 4;
   localparam int D  = 128;
   localparam int W  = 4;
   localparam int AW = 7;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req, req_we, req_lock;
   logic [N*W-1:0]    req_byte_en;
   logic [N*AW-1:0]   req_addr;
   logic [N*W*8-1:0]  req_wdata;
   logic [N-1:0]      gnt, rsp_valid;
   logic [W*8-1:0]    rsp_rdata, sram_wdata, sram_rdata;
   logic              sram_ce, sram_we;
   logic [W-1:0]      sram_byte_en;
   logic [AW-1:0]     sram_addr;

   int errors = 0;
   int checks = 0;
   logic [35:0] exp_q[$];

   logic [31:0] mem [0:D-1];
   logic [31:0] rd_q;

   always #5 clk = ~clk;

   hgw_sram_arb #(.N(N), .D(D), .W(W), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_lock(req_lock),
      .req_byte_en(req_byte_en), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sram_ce(sram_ce), .sram_we(sram_we), .sram_byte_en(sram_byte_en),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // Single-port SRAM: read register only updates on reads.
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) begin
            for (int b = 0; b < W; b++)
               if (sram_byte_en[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end else begin
            rd_q <= mem[sram_addr];
         end
      end
   end
   assign sram_rdata = rd_q;

   function automatic logic [31:0] init_val(int a);
      return {8'hC0, 8'(a), 8'h5A, 8'(a)};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid !== '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected rsp: got rsp_valid %b expected none", rsp_valid);
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e[35:32]));
            chk("rsp_rdata", rsp_rdata, e[31:0]);
         end
      end
   end

   task automatic drive(int i, logic we, logic lk, logic [3:0] be, logic [6:0] a, logic [31:0] d);
      req[i]               = 1'b1;
      req_we[i]            = we;
      req_lock[i]          = lk;
      req_byte_en[i*W +: W] = be;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   task automatic idle_all();
      req = '0; req_we = '0; req_lock = '0;
   endtask

   // Checks grant/ce at negedge and queues the expected read response.
   task automatic cyc(logic [3:0] eg, logic [31:0] edata, string nm, bit expect_rsp = 1'b1);
      @(negedge clk);
      chk({nm, " gnt"}, 32'(gnt), 32'(eg));
      chk({nm, " ce"}, 32'(sram_ce), 32'(|eg));
      if (expect_rsp) begin
         for (int i = 0; i < N; i++)
            if (eg[i] && !req_we[i]) exp_q.push_back({eg, edata});
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic flush(string nm);
      idle_all();
      cyc(4'b0000, 32'h0, nm);
      nxt();
      @(negedge clk);
      chk({nm, " rsp quiet"}, 32'(rsp_valid), 32'h0);
      nxt();
   endtask

   task automatic do_reset();
      idle_all();
      rst_n = 1'b0;
      #1;
      chk("reset gnt", 32'(gnt), 32'h0);
      chk("reset ce", 32'(sram_ce), 32'h0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
      nxt();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < D; a++) mem[a] = init_val(a);
      rd_q = '0;
      rst_n = 1'b0;
      idle_all();
      req_byte_en = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Two simultaneous reads, round-robin from 0
      drive(0, 1'b0, 1'b0, 4'hF, 7'd5, 32'h0);
      drive(1, 1'b0, 1'b0, 4'hF, 7'd9, 32'h0);
      cyc(4'b0001, init_val(5), "t1 c0");
      chk("t1 addr0", 32'(sram_addr), 32'd5);
      nxt();
      req[0] = 1'b0;
      cyc(4'b0010, init_val(9), "t1 c1");
      chk("t1 addr1", 32'(sram_addr), 32'd9);
      nxt();
      flush("t1");

      // Byte-masked write then read back
      drive(1, 1'b1, 1'b0, 4'hF, 7'd3, 32'h11223344);
      cyc(4'b0010, 32'h0, "t2 full wr");
      nxt();
      drive(1, 1'b1, 1'b0, 4'b0101, 7'd3, 32'hAABBCCDD);
      cyc(4'b0010, 32'h0, "t2 byte wr");
      chk("t2 we", 32'(sram_we), 32'h1);
      chk("t2 be", 32'(sram_byte_en), 32'h5);
      chk("t2 wdata", sram_wdata, 32'hAABBCCDD);
      nxt();
      drive(1, 1'b0, 1'b0, 4'hF, 7'd3, 32'h0);
      cyc(4'b0010, 32'h11BB33DD, "t2 rd");
      nxt();
      flush("t2");

      // Lock: requester 0 holds for 4 grants, then 1, then back to 0
      drive(0, 1'b0, 1'b1, 4'hF, 7'd5, 32'h0);
      drive(1, 1'b0, 1'b0, 4'hF, 7'd9, 32'h0);
      for (int k = 0; k < 4; k++) begin
         cyc(4'b0001, init_val(5), "t3 hold");
         nxt();
      end
      cyc(4'b0010, init_val(9), "t3 other");
      nxt();
      req[1] = 1'b0;
      req_lock[0] = 1'b0;
      cyc(4'b0001, init_val(5), "t3 back");
      nxt();
      flush("t3");

      // Fairness with all four requesting
      do_reset();
      for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 4'hF, 7'(10 + i), 32'h0);
      for (int k = 0; k < 8; k++) begin
         cyc(4'(1 << (k % 4)), init_val(10 + k % 4), "t4 rr");
         nxt();
      end
      flush("t4");

      // Read, write, idle: read data survives the following write
      drive(2, 1'b0, 1'b0, 4'hF, 7'd7, 32'h0);
      cyc(4'b0100, init_val(7), "t5 rd");
      nxt();
      req[2] = 1'b0;
      drive(0, 1'b1, 1'b0, 4'hF, 7'd7, 32'hDEADBEEF);
      cyc(4'b0001, 32'h0, "t5 wr");
      nxt();
      idle_all();
      cyc(4'b0000, 32'h0, "t5 idle");
      chk("t5 no rsp", 32'(rsp_valid), 32'h0);
      nxt();
      drive(3, 1'b0, 1'b0, 4'hF, 7'd7, 32'h0);
      cyc(4'b1000, 32'hDEADBEEF, "t5 raw");
      nxt();
      flush("t5");

      // Async reset with a pending response and a live lock
      drive(1, 1'b0, 1'b1, 4'hF, 7'd9, 32'h0);
      cyc(4'b0010, 32'h0, "t6 lock", 1'b0);
      nxt();
      drive(0, 1'b0, 1'b0, 4'hF, 7'd5, 32'h0);
      #1;
      chk("t6 held gnt", 32'(gnt), 32'h2);
      chk("t6 pending", 32'(rsp_valid), 32'h2);
      rst_n = 1'b0;
      #1;
      chk("t6 rst rsp", 32'(rsp_valid), 32'h0);
      chk("t6 rst gnt", 32'(gnt), 32'h0);
      chk("t6 rst ce", 32'(sram_ce), 32'h0);
      nxt();
      rst_n = 1'b1;
      cyc(4'b0001, init_val(5), "t6 after");
      nxt();
      flush("t6");

      chk("scoreboard empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
